// File: rtl/axi4lite_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes, FSM states, index helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Word index of a byte address; the two byte-lane bits are dropped.
    function automatic logic [29:0] reg_idx(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/axi4lite_wstrb_merge.sv
// Byte-lane merge of a new write word into the old register contents under wstrb.
// Latency: purely combinational.
// Backpressure: none.
module axi4lite_wstrb_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_strb,
    output logic [31:0] o_merged
);

    // Each strobe bit selects the new byte for its lane, otherwise the old byte survives.
    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_strb[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
        end
    end

endmodule

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave: N_RW writable registers then N_RO external read-only registers from offset 0.
// Latency: write commits on the edge both AW and W are available (B next cycle); read data 1 cycle after AR.
// Backpressure: one outstanding write and one outstanding read; B/R held until ready. Option: AXIL_REGBANK_WR_PULSE_EN.
module axi4lite_regbank
    import axi4lite_regbank_pkg::*;
#(
    parameter int          N_RW     = 9,
    parameter int          N_RO     = 6,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RW_RESET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
`ifdef AXIL_REGBANK_WR_PULSE_EN
    output logic [N_RW-1:0]      wr_pulse,
`endif
    output logic [32*N_RW-1:0]   rw_regs,
    input  logic [32*N_RO-1:0]   ro_regs
);

    logic        r_ready_en;
    logic [31:0] r_regs [N_RW];

    // Keep every ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ready_en <= 1'b0;
        else         r_ready_en <= 1'b1;
    end

    // ---------------- write path ----------------
    wr_state_t         r_wr_state;
    logic              r_aw_held, r_w_held;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              w_aw_fire, w_w_fire, w_commit, w_wr_ok;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_wr_data, w_wr_old, w_merged, w_wr_idx;
    logic [3:0]        w_wr_strb;

    assign s_axi_awready = r_ready_en && (r_wr_state == WR_IDLE) && !r_aw_held;
    assign s_axi_wready  = r_ready_en && (r_wr_state == WR_IDLE) && !r_w_held;
    assign w_aw_fire     = s_axi_awvalid && s_axi_awready;
    assign w_w_fire      = s_axi_wvalid && s_axi_wready;
    // Commit as soon as both halves are available, whether latched earlier or arriving now.
    assign w_commit      = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_wr_addr     = r_aw_held ? r_awaddr : s_axi_awaddr;
    assign w_wr_data     = r_w_held  ? r_wdata  : s_axi_wdata;
    assign w_wr_strb     = r_w_held  ? r_wstrb  : s_axi_wstrb;
    assign w_wr_idx      = {2'b00, reg_idx(32'(w_wr_addr))};
    assign w_wr_ok       = w_wr_idx < 32'(N_RW);
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;

    // Current contents of the register targeted by the pending write.
    always_comb begin
        w_wr_old = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (w_wr_idx == 32'(k)) w_wr_old = r_regs[k];
        end
    end

    axi4lite_wstrb_merge u_merge (
        .i_old    (w_wr_old),
        .i_new    (w_wr_data),
        .i_strb   (w_wr_strb),
        .o_merged (w_merged)
    );

    // Write FSM: latch AW/W independently, commit, then hold B until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= WR_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_fire) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axi_awaddr;
                    end
                    if (w_w_fire) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axi_wdata;
                        r_wstrb  <= s_axi_wstrb;
                    end
                    if (w_commit) begin
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= WR_RESP;
                    end
                end
                default: begin
                    if (r_bvalid && s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    // RW register array: only an in-range committed write touches state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_RW; k++) r_regs[k] <= RW_RESET;
        end else begin
            for (int k = 0; k < N_RW; k++) begin
                if (w_commit && w_wr_ok && (w_wr_idx == 32'(k))) r_regs[k] <= w_merged;
            end
        end
    end

    // Flatten the register array onto the output bus.
    always_comb begin
        rw_regs = '0;
        for (int k = 0; k < N_RW; k++) rw_regs[32*k +: 32] = r_regs[k];
    end

`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [N_RW-1:0] r_wr_pulse;

    // One-cycle strobe aligned with the first cycle the register shows its new value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_pulse <= '0;
        end else begin
            for (int k = 0; k < N_RW; k++) begin
                r_wr_pulse[k] <= w_commit && w_wr_ok && (w_wr_idx == 32'(k));
            end
        end
    end

    assign wr_pulse = r_wr_pulse;
`endif

    // ---------------- read path ----------------
    rd_state_t   r_rd_state;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] w_rd_idx, w_rd_data;
    logic [1:0]  w_rd_resp;

    assign s_axi_arready = r_ready_en && (r_rd_state == RD_IDLE);
    assign w_rd_idx      = {2'b00, reg_idx(32'(s_axi_araddr))};
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    // Read decode: RW array, then RO inputs; anything else reads zero with SLVERR.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        for (int k = 0; k < N_RW; k++) begin
            if (w_rd_idx == 32'(k)) begin
                w_rd_data = r_regs[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < N_RO; k++) begin
            if (w_rd_idx == 32'(N_RW + k)) begin
                w_rd_data = ro_regs[32*k +: 32];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    // Read FSM: register the decoded word on AR, hold it until R is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= RD_DATA;
                    end
                end
                default: begin
                    if (r_rvalid && s_axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank (default parameters, 9 RW + 6 RO registers).
// Table of single transactions plus directed sequences for multi-cycle corners.
// Optional checks for AXIL_REGBANK_WR_PULSE_EN when the macro is defined.
module tb_axi4lite_regbank;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [7:0]   s_axi_awaddr = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [7:0]   s_axi_araddr = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [32*9-1:0] rw_regs;
    logic [32*6-1:0] ro_regs;
`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [8:0]   wr_pulse;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi4lite_regbank dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
`ifdef AXIL_REGBANK_WR_PULSE_EN
        .wr_pulse      (wr_pulse),
`endif
        .rw_regs       (rw_regs),
        .ro_regs       (ro_regs)
    );

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write: AW and W together, then accept B.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int n = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_f) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  s_axi_wvalid = 1'b0; end
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin tick(); n++; end
        if (!s_axi_bvalid) begin
            check("write_timeout", 0, 1);
            resp = 2'bxx;
        end else begin
            resp = s_axi_bresp;
            tick();
        end
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin tick(); n++; end
        if (!s_axi_rvalid) begin
            check("read_timeout", 0, 1);
            data = 'x; resp = 'x;
        end else begin
            data = s_axi_rdata; resp = s_axi_rresp;
            tick();
        end
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [32*9-1:0] snap;

        ro_regs = '0;
        ro_regs[31:0]    = 32'hCAFE_F00D;
        ro_regs[63:32]   = 32'h1111_2222;
        ro_regs[191:160] = 32'h5555_AAAA;

        //        wr    addr   data          strb  resp   rdata
        vecs[0]  = '{1'b1, 8'h00, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0022_0044};
        vecs[2]  = '{1'b0, 8'h04, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 8'h24, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 8'h3C, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 8'h20, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b1, 8'h20, 32'h0000_FF00, 4'h2, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 8'h20, 32'h0,         4'h0, 2'b00, 32'hA5A5_FFA5};
        vecs[9]  = '{1'b1, 8'h07, 32'h0000_0055, 4'h1, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 8'h04, 32'h0,         4'h0, 2'b00, 32'hDEAD_BE55};
        vecs[11] = '{1'b0, 8'h38, 32'h0,         4'h0, 2'b00, 32'h5555_AAAA};
        vecs[12] = '{1'b0, 8'hFC, 32'h0,         4'h0, 2'b10, 32'h0};

        // Reset state
        #12;
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready",  s_axi_wready,  0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_bvalid",  s_axi_bvalid,  0);
        check("rst_rvalid",  s_axi_rvalid,  0);
        check("rst_bresp",   s_axi_bresp,   0);
        check("rst_rresp",   s_axi_rresp,   0);
        check("rst_rdata",   s_axi_rdata,   0);
        check("rst_rw_regs", rw_regs,       0);
        resetn = 1'b1;
        tick();
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_arready", s_axi_arready, 1);

        // AW at cycle 0, W at cycle 3, B at cycle 4
        s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        tick();
        check("aw_held_awready", s_axi_awready, 0);
        check("aw_held_wready",  s_axi_wready,  1);
        tick();
        s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("split_bvalid", s_axi_bvalid, 1);
        check("split_bresp",  s_axi_bresp,  0);
        check("split_reg1",   rw_regs[63:32], 32'hDEAD_BEEF);
        check("split_awready_resp", s_axi_awready, 0);
`ifdef AXIL_REGBANK_WR_PULSE_EN
        check("pulse_on",  wr_pulse, 9'h002);
`endif
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("split_bvalid_clr", s_axi_bvalid, 0);
`ifdef AXIL_REGBANK_WR_PULSE_EN
        check("pulse_off", wr_pulse, 9'h000);
`endif

        // Table-driven single transactions
        for (int i = 0; i < 13; i++) begin
            snap = rw_regs;
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                if (vecs[i].exp_resp == 2'b10)
                    check($sformatf("vec%0d_noupd", i), rw_regs, snap);
            end else begin
                do_read(vecs[i].addr, rdata, resp);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end

        // RO read with R backpressure for 5 cycles
        s_axi_araddr = 8'h24; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_rvalid", c),  s_axi_rvalid,  1);
            check($sformatf("bp%0d_rdata", c),   s_axi_rdata,   32'hCAFE_F00D);
            check($sformatf("bp%0d_arready", c), s_axi_arready, 0);
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("bp_rvalid_clr", s_axi_rvalid, 0);
        check("bp_arready_back", s_axi_arready, 1);

        // Same-cycle read and write commit on 0x08
        do_write(8'h08, 32'h1, 4'hF, resp);
        check("rw_pre_bresp", resp, 0);
        s_axi_awaddr = 8'h08; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("coll_rvalid", s_axi_rvalid, 1);
        check("coll_rdata_old", s_axi_rdata, 32'h1);
        check("coll_bvalid", s_axi_bvalid, 1);
        check("coll_reg2_new", rw_regs[95:64], 32'h2);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        do_read(8'h08, rdata, resp);
        check("coll_rdata_new", rdata, 32'h2);

        // Reset while B is pending
        s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        check("pend_bvalid", s_axi_bvalid, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_bvalid", s_axi_bvalid, 0);
        check("mid_rst_rw_regs", rw_regs, 0);
        check("mid_rst_awready", s_axi_awready, 0);
`ifdef AXIL_REGBANK_WR_PULSE_EN
        check("mid_rst_pulse", wr_pulse, 0);
`endif
        tick();
        resetn = 1'b1;
        tick();
        check("rerst_awready", s_axi_awready, 1);
        check("rerst_wready",  s_axi_wready,  1);
        check("rerst_bvalid",  s_axi_bvalid,  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
